// File: rtl/pll_spi_master_if.sv
// Command/response bus between on-chip logic and the PLL SPI master.
// The master modport is the requesting logic; the slave modport is the
// SPI master block that serves the commands.
interface pll_spi_master_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_rw;
  logic [6:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       busy;

  modport master (
    output cmd_valid, cmd_rw, cmd_addr, cmd_wdata,
    input  cmd_ready, rsp_valid, rsp_rdata, busy
  );

  modport slave (
    input  cmd_valid, cmd_rw, cmd_addr, cmd_wdata,
    output cmd_ready, rsp_valid, rsp_rdata, busy
  );
endinterface

// File: rtl/pll_spi_master.sv
// SPI master (mode 0, MSB first, 16-bit frames) for the PLL control
// registers. Each accepted command becomes one frame
// {rw, addr[6:0], data[7:0]}; reads return the byte sampled on SCK
// rising edges 9..16. Every output is a flop that changes together with
// the state register, so a command accepted on one edge shows CS low
// right after it.
module pll_spi_master #(
  parameter int unsigned DIV = 4  // SCK half-period in clk_i cycles, 2..255
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  pll_spi_master_if.slave bus,
  output logic            spi_sck,
  output logic            spi_cs_n,
  output logic            spi_mosi,
  input  logic            spi_miso
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } state_e;

  localparam logic [7:0] DIV_M1 = 8'(DIV - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;        // cycles left in the current half-period
  logic [3:0]  fall_q, fall_d;      // SCK falling edges completed so far
  logic [15:0] tx_q, tx_d;          // outgoing frame, MSB is on MOSI
  logic [7:0]  rx_q, rx_d;          // last eight MISO samples
  logic        rw_q, rw_d;
  logic        sck_q, sck_d;
  logic        cs_n_q, cs_n_d;
  logic        mosi_q, mosi_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [7:0]  rsp_rdata_q, rsp_rdata_d;
  logic        busy_q, busy_d;
  logic        ready_q, ready_d;
  logic        accept;
  logic [15:0] frame;

  // Next-state and next-output logic for the frame sequencer.
  always_comb begin
    // NOTE: every target gets a default first so no path leaves one unassigned (no latches).
    state_d     = state_q;
    cnt_d       = cnt_q;
    fall_d      = fall_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    rw_d        = rw_q;
    sck_d       = sck_q;
    cs_n_d      = cs_n_q;
    mosi_d      = mosi_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;

    accept = bus.cmd_valid && ready_q;
    frame  = {bus.cmd_rw, bus.cmd_addr, (bus.cmd_rw ? 8'h00 : bus.cmd_wdata)};

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SETUP;
          cnt_d   = DIV_M1;
          fall_d  = '0;
          tx_d    = frame;
          rx_d    = '0;
          rw_d    = bus.cmd_rw;
          sck_d   = 1'b0;
          cs_n_d  = 1'b0;
          mosi_d  = frame[15];
        end
      end

      SETUP: begin
        if (cnt_q == 8'd0) begin
          state_d = SHIFT;
          cnt_d   = DIV_M1;
          sck_d   = 1'b1;
          rx_d    = {rx_q[6:0], spi_miso};
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      SHIFT: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          cnt_d = DIV_M1;
          if (!sck_q) begin
            // Rising edge: sample MISO; after 16 rises rx holds bits 9..16.
            sck_d = 1'b1;
            rx_d  = {rx_q[6:0], spi_miso};
          end else begin
            sck_d = 1'b0;
            if (fall_q == 4'd15) begin
              state_d = HOLD;
              mosi_d  = 1'b0;
            end else begin
              fall_d = fall_q + 4'd1;
              tx_d   = {tx_q[14:0], 1'b0};
              mosi_d = tx_q[14];
            end
          end
        end
      end

      HOLD: begin
        if (cnt_q == 8'd0) begin
          state_d     = GAP;
          cnt_d       = DIV_M1;
          cs_n_d      = 1'b1;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = rw_q ? rx_q : 8'h00;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      GAP: begin
        if (cnt_q == 8'd0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      default: state_d = IDLE;
    endcase

    busy_d  = (state_d != IDLE);
    ready_d = (state_d == IDLE);
  end

  // State and output registers; reset aborts any frame and parks the bus.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!rst_ni) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      fall_q      <= '0;
      tx_q        <= '0;
      rx_q        <= '0;
      rw_q        <= 1'b0;
      sck_q       <= 1'b0;
      cs_n_q      <= 1'b1;
      mosi_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      busy_q      <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      fall_q      <= fall_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      rw_q        <= rw_d;
      sck_q       <= sck_d;
      cs_n_q      <= cs_n_d;
      mosi_q      <= mosi_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      busy_q      <= busy_d;
      ready_q     <= ready_d;
    end
  end

  assign spi_sck       = sck_q;
  assign spi_cs_n      = cs_n_q;
  assign spi_mosi      = mosi_q;
  assign bus.cmd_ready = ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_pll_spi_master.sv
// Self-checking bench for pll_spi_master. Two instances (DIV=4, DIV=2)
// share the clock and reset; 'sel' picks which one is driven and watched.
// A behavioural PLL slave shifts a 16-bit word out on MISO, and expected
// frames, read data and cycle positions come from the frame rules.
module tb_pll_spi_master;

  logic clk;
  logic rst_n;
  logic sel;
  logic cmd_valid, cmd_rw;
  logic [6:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic miso;

  pll_spi_master_if bus4();
  pll_spi_master_if bus2();
  logic sck4, cs4, mosi4, sck2, cs2, mosi2;

  assign bus4.cmd_valid = cmd_valid && !sel;
  assign bus4.cmd_rw    = cmd_rw;
  assign bus4.cmd_addr  = cmd_addr;
  assign bus4.cmd_wdata = cmd_wdata;
  assign bus2.cmd_valid = cmd_valid && sel;
  assign bus2.cmd_rw    = cmd_rw;
  assign bus2.cmd_addr  = cmd_addr;
  assign bus2.cmd_wdata = cmd_wdata;

  pll_spi_master #(.DIV(4)) u_dut4 (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus4),
    .spi_sck(sck4), .spi_cs_n(cs4), .spi_mosi(mosi4), .spi_miso(miso)
  );

  pll_spi_master #(.DIV(2)) u_dut2 (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus2),
    .spi_sck(sck2), .spi_cs_n(cs2), .spi_mosi(mosi2), .spi_miso(miso)
  );

  logic s_sck, s_cs_n, s_mosi, s_ready, s_rsp_valid, s_busy;
  logic [7:0] s_rdata;
  assign s_sck       = sel ? sck2 : sck4;
  assign s_cs_n      = sel ? cs2 : cs4;
  assign s_mosi      = sel ? mosi2 : mosi4;
  assign s_ready     = sel ? bus2.cmd_ready : bus4.cmd_ready;
  assign s_rsp_valid = sel ? bus2.rsp_valid : bus4.rsp_valid;
  assign s_busy      = sel ? bus2.busy : bus4.busy;
  assign s_rdata     = sel ? bus2.rsp_rdata : bus4.rsp_rdata;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural PLL slave: loads its word when CS falls, shifts after SCK falls.
  logic [15:0] slave_word = 16'h0000;
  logic [15:0] slave_sh   = 16'h0000;
  logic        prev_cs    = 1'b1;
  logic        prev_sck   = 1'b0;
  always begin
    @(posedge clk);
    #1;
    if (prev_cs && !s_cs_n) slave_sh = slave_word;
    else if (!s_cs_n && prev_sck && !s_sck) slave_sh = {slave_sh[14:0], 1'b0};
    miso     = slave_sh[15];
    prev_cs  = s_cs_n;
    prev_sck = s_sck;
  end

  // Measurements of the most recent frame (cycle 0 = acceptance cycle).
  int acc_wait, cs_fall_c, cs_rise_c, cs_high_tail, rises;
  int first_rise_c, last_rise_c, last_fall_c, mosi_bad, rsp_cnt, rsp_c, busy_bad, ready_c;
  logic [15:0] mosi_frame;
  logic [7:0]  rsp_data, held_data;

  function automatic logic [15:0] ref_frame(input logic rw, input logic [6:0] addr,
                                            input logic [7:0] wdata);
    return {rw, addr, (rw ? 8'h00 : wdata)};
  endfunction

  function automatic logic [7:0] ref_rdata(input logic rw, input logic [7:0] slave_byte);
    return rw ? slave_byte : 8'h00;
  endfunction

  // Issue one command (called at a negedge) and record everything up to the
  // cycle where cmd_ready should return. With 'hold', cmd_valid stays high
  // carrying the next command; with 'scramble', addr/data churn every cycle.
  task automatic run_cmd(input int div, input logic rw, input logic [6:0] addr,
                         input logic [7:0] wdata, input bit hold, input bit scramble,
                         input logic n_rw, input logic [6:0] n_addr, input logic [7:0] n_wdata);
    int t;
    int last;
    logic psck, pmosi;
    cmd_rw = rw; cmd_addr = addr; cmd_wdata = wdata; cmd_valid = 1'b1;
    cs_fall_c = -1; cs_rise_c = -1; cs_high_tail = 0; rises = 0;
    first_rise_c = -1; last_rise_c = -1; last_fall_c = -1; mosi_bad = 0;
    rsp_cnt = 0; rsp_c = -1; busy_bad = 0; ready_c = -1;
    mosi_frame = 16'h0; rsp_data = 8'hxx; held_data = 8'hxx;
    t = 0;
    while (s_ready !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    acc_wait = t;
    n_checks++;
    if (t >= 200) begin
      $display("FAIL accept_timeout: cmd_ready still %b after %0d cycles, want 1", s_ready, t);
      cmd_valid = 1'b0;
      return;
    end
    n_pass++;
    psck  = s_sck;
    pmosi = s_mosi;
    last  = 1 + 34 * div;
    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      if (c == 1) begin
        if (hold) begin
          cmd_rw = n_rw; cmd_addr = n_addr; cmd_wdata = n_wdata;
        end else begin
          cmd_valid = 1'b0;
        end
      end
      if (scramble) begin
        cmd_addr  = 7'($urandom);
        cmd_wdata = 8'($urandom);
      end
      if (s_cs_n === 1'b0 && cs_fall_c < 0) cs_fall_c = c;
      if (s_cs_n === 1'b1 && cs_fall_c >= 0 && cs_rise_c < 0) cs_rise_c = c;
      if (cs_rise_c >= 0 && s_cs_n === 1'b1) cs_high_tail++;
      if (!psck && s_sck) begin
        rises++;
        mosi_frame = {mosi_frame[14:0], s_mosi};
        if (first_rise_c < 0) first_rise_c = c;
        last_rise_c = c;
      end
      if (psck && !s_sck) last_fall_c = c;
      if (s_sck && s_mosi !== pmosi) mosi_bad++;
      if (s_rsp_valid === 1'b1) begin
        rsp_cnt++;
        rsp_c    = c;
        rsp_data = s_rdata;
      end
      if (s_busy !== (c <= 34 * div)) busy_bad++;
      if (s_ready === 1'b1 && ready_c < 0) ready_c = c;
      psck  = s_sck;
      pmosi = s_mosi;
    end
    held_data = s_rdata;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; sel = 1'b0; cmd_valid = 1'b0; cmd_rw = 1'b0;
    cmd_addr = '0; cmd_wdata = '0; miso = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({cs4, sck4, mosi4, bus4.rsp_valid, bus4.rsp_rdata, bus4.busy, bus4.cmd_ready} !== 14'b1000_0000_0000_00)
      $display("FAIL reset_div4: got cs/sck/mosi/rv/rd/busy/rdy=%b%b%b %b %h %b %b, want 100 0 00 0 0",
               cs4, sck4, mosi4, bus4.rsp_valid, bus4.rsp_rdata, bus4.busy, bus4.cmd_ready);
    else n_pass++;
    n_checks++;
    if ({cs2, sck2, mosi2, bus2.rsp_valid, bus2.rsp_rdata, bus2.busy, bus2.cmd_ready} !== 14'b1000_0000_0000_00)
      $display("FAIL reset_div2: got cs/sck/mosi/rv/rd/busy/rdy=%b%b%b %b %h %b %b, want 100 0 00 0 0",
               cs2, sck2, mosi2, bus2.rsp_valid, bus2.rsp_rdata, bus2.busy, bus2.cmd_ready);
    else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({bus4.cmd_ready, bus2.cmd_ready} !== 2'b11)
      $display("FAIL reset_ready: got %b%b, want 11", bus4.cmd_ready, bus2.cmd_ready);
    else n_pass++;
  endtask

  task automatic test_write();
    sel = 1'b0;
    slave_word = 16'($urandom);
    run_cmd(4, 1'b0, 7'h12, 8'h5A, 1'b0, 1'b0, 1'b0, 7'h0, 8'h0);
    n_checks++; if (mosi_frame !== 16'h125A) $display("FAIL write_frame: got %h, want 125a", mosi_frame); else n_pass++;
    n_checks++; if (rises !== 16) $display("FAIL write_pulses: got %0d, want 16", rises); else n_pass++;
    n_checks++; if (cs_fall_c !== 1) $display("FAIL write_cs_fall: got %0d, want 1", cs_fall_c); else n_pass++;
    n_checks++; if (cs_rise_c !== 133) $display("FAIL write_cs_rise: got %0d, want 133", cs_rise_c); else n_pass++;
    n_checks++; if (first_rise_c !== 5) $display("FAIL write_first_rise: got %0d, want 5", first_rise_c); else n_pass++;
    n_checks++; if (last_rise_c !== 125) $display("FAIL write_last_rise: got %0d, want 125", last_rise_c); else n_pass++;
    n_checks++; if (last_fall_c !== 129) $display("FAIL write_last_fall: got %0d, want 129", last_fall_c); else n_pass++;
    n_checks++; if (rsp_c !== 133 || rsp_cnt !== 1) $display("FAIL write_rsp: got cycle %0d count %0d, want 133 1", rsp_c, rsp_cnt); else n_pass++;
    n_checks++; if (rsp_data !== 8'h00) $display("FAIL write_rdata: got %h, want 00", rsp_data); else n_pass++;
    n_checks++; if (busy_bad !== 0) $display("FAIL write_busy: got %0d bad cycles, want 0", busy_bad); else n_pass++;
    n_checks++; if (ready_c !== 137) $display("FAIL write_ready: got %0d, want 137", ready_c); else n_pass++;
    n_checks++; if (mosi_bad !== 0) $display("FAIL write_mosi_high: got %0d changes with SCK high, want 0", mosi_bad); else n_pass++;
  endtask

  task automatic test_read();
    sel = 1'b0;
    slave_word = {8'($urandom), 8'hA5};
    run_cmd(4, 1'b1, 7'h03, 8'($urandom), 1'b0, 1'b0, 1'b0, 7'h0, 8'h0);
    n_checks++; if (mosi_frame !== 16'h8300) $display("FAIL read_frame: got %h, want 8300", mosi_frame); else n_pass++;
    n_checks++; if (rsp_data !== 8'hA5) $display("FAIL read_rdata: got %h, want a5", rsp_data); else n_pass++;
    n_checks++; if (rsp_cnt !== 1) $display("FAIL read_rsp_count: got %0d, want 1", rsp_cnt); else n_pass++;
    n_checks++; if (held_data !== 8'hA5) $display("FAIL read_rdata_hold: got %h, want a5", held_data); else n_pass++;
  endtask

  task automatic test_stability();
    logic [6:0] a;
    logic [7:0] d;
    sel = 1'b0;
    a = 7'($urandom);
    d = 8'($urandom);
    slave_word = 16'($urandom);
    run_cmd(4, 1'b0, a, d, 1'b0, 1'b1, 1'b0, 7'h0, 8'h0);
    n_checks++;
    if (mosi_frame !== ref_frame(1'b0, a, d))
      $display("FAIL stable_frame: got %h, want %h", mosi_frame, ref_frame(1'b0, a, d));
    else n_pass++;
    n_checks++; if (rsp_data !== 8'h00) $display("FAIL stable_rdata: got %h, want 00", rsp_data); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [6:0] a1, a2;
    logic [7:0] d1, b2;
    int extra;
    sel = 1'b0;
    a1 = 7'($urandom); d1 = 8'($urandom);
    a2 = 7'($urandom); b2 = 8'($urandom);
    slave_word = 16'($urandom);
    run_cmd(4, 1'b0, a1, d1, 1'b1, 1'b0, 1'b1, a2, 8'h00);
    n_checks++; if (mosi_frame !== ref_frame(1'b0, a1, d1)) $display("FAIL b2b_frame1: got %h, want %h", mosi_frame, ref_frame(1'b0, a1, d1)); else n_pass++;
    n_checks++; if (ready_c !== 137) $display("FAIL b2b_second_accept: got %0d, want 137", ready_c); else n_pass++;
    n_checks++; if (cs_high_tail < 4) $display("FAIL b2b_cs_gap: got %0d cycles, want >=4", cs_high_tail); else n_pass++;
    slave_word = {8'($urandom), b2};
    run_cmd(4, 1'b1, a2, 8'h00, 1'b0, 1'b0, 1'b0, 7'h0, 8'h0);
    n_checks++; if (acc_wait !== 0) $display("FAIL b2b_wait: got %0d, want 0", acc_wait); else n_pass++;
    n_checks++; if (mosi_frame !== ref_frame(1'b1, a2, 8'h00)) $display("FAIL b2b_frame2: got %h, want %h", mosi_frame, ref_frame(1'b1, a2, 8'h00)); else n_pass++;
    n_checks++; if (rsp_data !== b2) $display("FAIL b2b_rdata2: got %h, want %h", rsp_data, b2); else n_pass++;
    extra = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (s_cs_n !== 1'b1 || s_rsp_valid !== 1'b0) extra++;
    end
    n_checks++; if (extra !== 0) $display("FAIL b2b_no_duplicate: got %0d active cycles, want 0", extra); else n_pass++;
  endtask

  task automatic test_random();
    int div;
    logic rw;
    logic [6:0] a;
    logic [7:0] d, b;
    for (int i = 0; i < 8; i++) begin
      sel = 1'($urandom_range(0, 1));
      div = sel ? 2 : 4;
      rw = 1'($urandom); a = 7'($urandom); d = 8'($urandom); b = 8'($urandom);
      slave_word = {8'($urandom), b};
      run_cmd(div, rw, a, d, 1'b0, 1'b0, 1'b0, 7'h0, 8'h0);
      n_checks++;
      if (mosi_frame !== ref_frame(rw, a, d))
        $display("FAIL rand%0d_frame: got %h, want %h", i, mosi_frame, ref_frame(rw, a, d));
      else n_pass++;
      n_checks++;
      if (rsp_data !== ref_rdata(rw, b) || rsp_cnt !== 1 || rsp_c !== 1 + 33 * div)
        $display("FAIL rand%0d_rsp: got data %h count %0d cycle %0d, want %h 1 %0d",
                 i, rsp_data, rsp_cnt, rsp_c, ref_rdata(rw, b), 1 + 33 * div);
      else n_pass++;
      n_checks++;
      if (ready_c !== 1 + 34 * div)
        $display("FAIL rand%0d_ready: got %0d, want %0d", i, ready_c, 1 + 34 * div);
      else n_pass++;
    end
    sel = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    int r, t, bad;
    logic psck;
    logic [6:0] a;
    logic [7:0] d;
    sel = 1'b0;
    cmd_rw = 1'b0; cmd_addr = 7'($urandom); cmd_wdata = 8'($urandom); cmd_valid = 1'b1;
    t = 0;
    while (s_ready !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    r = 0;
    psck = 1'b0;
    for (int i = 0; i < 400 && r < 7; i++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      if (!psck && s_sck) r++;
      psck = s_sck;
    end
    n_checks++; if (r !== 7) $display("FAIL midrst_reach_rise7: got %0d rises, want 7", r); else n_pass++;
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({s_cs_n, s_sck, s_mosi, s_rsp_valid, s_busy} !== 5'b10000)
      $display("FAIL midrst_outputs: got cs/sck/mosi/rv/busy=%b%b%b%b%b, want 10000", s_cs_n, s_sck, s_mosi, s_rsp_valid, s_busy);
    else n_pass++;
    n_checks++; if (s_rdata !== 8'h00) $display("FAIL midrst_rdata: got %h, want 00", s_rdata); else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (s_ready !== 1'b1) $display("FAIL midrst_ready: got %b, want 1", s_ready); else n_pass++;
    bad = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (s_rsp_valid !== 1'b0 || s_cs_n !== 1'b1) bad++;
    end
    n_checks++; if (bad !== 0) $display("FAIL midrst_no_rsp: got %0d active cycles, want 0", bad); else n_pass++;
    a = 7'($urandom); d = 8'($urandom);
    slave_word = 16'($urandom);
    run_cmd(4, 1'b0, a, d, 1'b0, 1'b0, 1'b0, 7'h0, 8'h0);
    n_checks++;
    if (mosi_frame !== ref_frame(1'b0, a, d) || rsp_c !== 133 || rsp_cnt !== 1)
      $display("FAIL midrst_followup: got frame %h rsp cycle %0d count %0d, want %h 133 1",
               mosi_frame, rsp_c, rsp_cnt, ref_frame(1'b0, a, d));
    else n_pass++;
  endtask

  task automatic test_div2_read();
    sel = 1'b1;
    slave_word = {8'($urandom), 8'h3C};
    run_cmd(2, 1'b1, 7'h03, 8'($urandom), 1'b0, 1'b0, 1'b0, 7'h0, 8'h0);
    n_checks++; if (mosi_frame !== 16'h8300) $display("FAIL div2_frame: got %h, want 8300", mosi_frame); else n_pass++;
    n_checks++; if (rsp_data !== 8'h3C || rsp_cnt !== 1) $display("FAIL div2_rdata: got %h count %0d, want 3c 1", rsp_data, rsp_cnt); else n_pass++;
    n_checks++; if (rsp_c !== 67) $display("FAIL div2_rsp_cycle: got %0d, want 67", rsp_c); else n_pass++;
    n_checks++; if (ready_c !== 69) $display("FAIL div2_ready: got %0d, want 69", ready_c); else n_pass++;
    n_checks++; if (rises !== 16 || cs_fall_c !== 1 || cs_rise_c !== 67) $display("FAIL div2_shape: got pulses %0d cs %0d..%0d, want 16 1..67", rises, cs_fall_c, cs_rise_c); else n_pass++;
    n_checks++; if (busy_bad !== 0 || mosi_bad !== 0) $display("FAIL div2_busy_mosi: got %0d %0d bad cycles, want 0 0", busy_bad, mosi_bad); else n_pass++;
    sel = 1'b0;
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_stability();
    test_back_to_back();
    test_random();
    test_reset_mid_frame();
    test_div2_read();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
